ram_bist_ctrl: RTL and testbench

- Synthesizable built-in self-test controller that acts as the initiator on the single-port RAM interface. It takes over the role that bench stimulus plays today.
- It drives wr_enb/rd_enb/addr/data_in into the `ram` block and checks the returned data_out using a March C- algorithm.
- It reports pass/fail, the first failing address and an error count. It sits beside the RAM and is muxed onto the RAM port while busy.

---
 rtl/ram_bist_ctrl_if.sv | 27 ++
 rtl/ram_bist_ctrl.sv | 141 ++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_bist_ctrl_if.sv
// rtl/ram_bist_ctrl_if.sv - single-port RAM access bus between BIST controller and RAM
interface ram_bist_ctrl_if #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_enb;
    logic                  rd_enb;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output wr_enb,
        output rd_enb,
        output addr,
        output data_in,
        input  data_out
    );

    modport slave (
        input  wr_enb,
        input  rd_enb,
        input  addr,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/ram_bist_ctrl.sv
// rtl/ram_bist_ctrl.sv - March C- built-in self-test controller for a single-port RAM
module ram_bist_ctrl #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int ERR_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    ram_bist_ctrl_if.master       ram,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_WIDTH-1:0] fail_addr,
    output logic [ERR_WIDTH-1:0]  err_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_CMP,
        S_DONE
    } state_t;

    localparam logic [2:0] LAST_ELEM = 3'd5;

    state_t                state, state_nxt;
    logic [2:0]            elem, elem_nxt;
    logic [ADDR_WIDTH-1:0] addr_q, addr_nxt;
    logic [DATA_WIDTH-1:0] data_q, data_nxt;
    logic [ERR_WIDTH-1:0]  err_nxt;
    logic [ADDR_WIDTH-1:0] fail_nxt;
    logic                  pass_nxt;

    logic                  desc;
    logic                  last_addr;
    logic [2:0]            elem_inc;
    logic                  desc_inc;
    logic [DATA_WIDTH-1:0] exp_pat;
    logic [DATA_WIDTH-1:0] wr_pat_inc;
    logic                  mismatch;
    logic                  advance;

    // Elements 3 and 4 walk downwards; odd elements read P0 and write P1.
    assign desc       = (elem == 3'd3) || (elem == 3'd4);
    assign last_addr  = desc ? (addr_q == '0) : (addr_q == {ADDR_WIDTH{1'b1}});
    assign elem_inc   = elem + 3'd1;
    assign desc_inc   = (elem_inc == 3'd3) || (elem_inc == 3'd4);
    assign exp_pat    = elem[0] ? {DATA_WIDTH{1'b0}} : {DATA_WIDTH{1'b1}};
    assign wr_pat_inc = elem_inc[0] ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
    assign mismatch   = (state == S_CMP) && (ram.data_out != exp_pat);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            elem      <= '0;
            addr_q    <= '0;
            data_q    <= '0;
            err_count <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
        end else begin
            state     <= state_nxt;
            elem      <= elem_nxt;
            addr_q    <= addr_nxt;
            data_q    <= data_nxt;
            err_count <= err_nxt;
            fail_addr <= fail_nxt;
            pass      <= pass_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        elem_nxt  = elem;
        addr_nxt  = addr_q;
        data_nxt  = data_q;
        err_nxt   = err_count;
        fail_nxt  = fail_addr;
        pass_nxt  = pass;
        advance   = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_WR;
                    elem_nxt  = '0;
                    addr_nxt  = '0;
                    data_nxt  = '0;
                    err_nxt   = '0;
                    fail_nxt  = '0;
                    pass_nxt  = 1'b0;
                end
            end
            S_WR: advance = 1'b1;
            S_RD: state_nxt = S_CMP;
            S_CMP: begin
                // An empty counter means this is the first miscompare of the run.
                if (mismatch) begin
                    if (err_count == '0) begin
                        fail_nxt = addr_q;
                    end
                    if (!(&err_count)) begin
                        err_nxt = err_count + ERR_WIDTH'(1);
                    end
                end
                if (elem == LAST_ELEM) begin
                    advance = 1'b1;
                end else begin
                    state_nxt = S_WR;
                end
            end
            S_DONE: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        if (advance) begin
            if (!last_addr) begin
                addr_nxt  = desc ? (addr_q - ADDR_WIDTH'(1)) : (addr_q + ADDR_WIDTH'(1));
                state_nxt = (elem == 3'd0) ? S_WR : S_RD;
            end else if (elem == LAST_ELEM) begin
                state_nxt = S_DONE;
                pass_nxt  = (err_nxt == '0);
            end else begin
                elem_nxt  = elem_inc;
                addr_nxt  = desc_inc ? {ADDR_WIDTH{1'b1}} : {ADDR_WIDTH{1'b0}};
                data_nxt  = wr_pat_inc;
                state_nxt = S_RD;
            end
        end
    end

    assign ram.wr_enb  = (state == S_WR);
    assign ram.rd_enb  = (state == S_RD);
    assign ram.addr    = addr_q;
    assign ram.data_in = data_q;
    assign busy        = (state == S_WR) || (state == S_RD) || (state == S_CMP);
    assign done        = (state == S_DONE);

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// tb/tb_ram_bist_ctrl.sv - scoreboard bench for ram_bist_ctrl with a faulty-RAM model
module tb_ram_bist_ctrl;

    typedef struct {
        logic       wr;
        logic       rd;
        logic [3:0] addr;
        logic [7:0] data;
    } acc_t;

    typedef struct {
        logic       pass;
        int         err;
        int         fa;
        int         cyc;
    } res_t;

    logic clk = 1'b0;
    logic rst;
    logic start;
    logic start_b;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    logic       busy_a, done_a, pass_a;
    logic [3:0] fail_addr_a;
    logic [7:0] err_count_a;
    logic       busy_b, done_b, pass_b;
    logic [3:0] fail_addr_b;
    logic [1:0] err_count_b;

    logic [7:0] mem_a [16];
    logic [7:0] sa0_a [16];
    logic [7:0] sa1_a [16];

    acc_t acc_q[$];
    res_t res_q[$];

    ram_bist_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) ra ();
    ram_bist_ctrl_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) rb ();

    ram_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ERR_WIDTH(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .ram(ra.master),
        .busy(busy_a), .done(done_a), .pass(pass_a),
        .fail_addr(fail_addr_a), .err_count(err_count_a)
    );

    ram_bist_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .ERR_WIDTH(2)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .ram(rb.master),
        .busy(busy_b), .done(done_b), .pass(pass_b),
        .fail_addr(fail_addr_b), .err_count(err_count_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM A: stuck-at faults are applied to the stored value
    always @(posedge clk) begin
        if (ra.wr_enb) mem_a[ra.addr] <= (ra.data_in & ~sa0_a[ra.addr]) | sa1_a[ra.addr];
        if (ra.rd_enb) ra.data_out <= mem_a[ra.addr];
    end

    // RAM B: every cell stuck-at-0
    always @(posedge clk) begin
        if (rb.rd_enb) rb.data_out <= 8'h00;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h at cyc %0d", name, act, exp, cyc);
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < 16; i++) begin
            sa0_a[i] = 8'h00;
            sa1_a[i] = 8'h00;
        end
    endtask

    // March C- reference: expected bus activity per busy cycle, and the final result
    task automatic build_expected(input int n);
        logic [7:0] m [16];
        int errs;
        int fa;
        acc_t x;
        res_t r;
        errs = 0;
        fa = 0;
        for (int i = 0; i < 16; i++) m[i] = 8'h00;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 16; i++) begin
                int a;
                logic [7:0] expv;
                logic [7:0] w;
                a = (e == 3 || e == 4) ? 15 - i : i;
                if (e > 0) begin
                    x = '{wr: 1'b0, rd: 1'b1, addr: a[3:0], data: 8'h00};
                    acc_q.push_back(x);
                    x.rd = 1'b0;
                    acc_q.push_back(x);
                    expv = (e == 2 || e == 4) ? 8'hFF : 8'h00;
                    if (m[a] !== expv) begin
                        if (errs == 0) fa = a;
                        if (errs < 255) errs++;
                    end
                end
                if (e < 5) begin
                    w = (e == 1 || e == 3) ? 8'hFF : 8'h00;
                    x = '{wr: 1'b1, rd: 1'b0, addr: a[3:0], data: w};
                    acc_q.push_back(x);
                    m[a] = (w & ~sa0_a[a]) | sa1_a[a];
                end
            end
        end
        r.pass = (errs == 0);
        r.err  = errs;
        r.fa   = fa;
        r.cyc  = n + 241;
        res_q.push_back(r);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            if (busy_a) begin
                if (acc_q.size() == 0) begin
                    chk("acc_unexpected_busy", 1, 0);
                end else begin
                    acc_t x;
                    x = acc_q.pop_front();
                    chk("acc_enables", {ra.wr_enb, ra.rd_enb}, {x.wr, x.rd});
                    chk("acc_addr", ra.addr, x.addr);
                    if (x.wr) chk("acc_data", ra.data_in, x.data);
                end
            end else if (ra.wr_enb || ra.rd_enb) begin
                chk("acc_enable_while_idle", {ra.wr_enb, ra.rd_enb}, 0);
            end
            if (done_a) begin
                if (res_q.size() == 0) begin
                    chk("done_unexpected", 1, 0);
                end else begin
                    res_t r;
                    r = res_q.pop_front();
                    chk("done_cycle", cyc, r.cyc);
                    chk("done_pass", pass_a, r.pass);
                    chk("done_err_count", err_count_a, r.err);
                    if (!r.pass) chk("done_fail_addr", fail_addr_a, r.fa);
                    chk("done_busy", busy_a, 0);
                    chk("done_acc_left", acc_q.size(), 0);
                end
            end
        end
    end

    task automatic run_a(input int extra_start);
        int n;
        @(negedge clk);
        n = cyc;
        build_expected(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (res_q.size() > 0 && cyc < n + 300) begin
            @(negedge clk);
            start = (extra_start > 0 && cyc == n + extra_start);
        end
        start = 1'b0;
        if (res_q.size() > 0) begin
            chk("run_timeout", 1, 0);
            acc_q.delete();
            res_q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_enables"}, {ra.wr_enb, ra.rd_enb}, 0);
        chk({tag, "_addr"}, ra.addr, 0);
        chk({tag, "_data_in"}, ra.data_in, 0);
        chk({tag, "_busy_done"}, {busy_a, done_a}, 0);
        chk({tag, "_pass"}, pass_a, 0);
        chk({tag, "_fail_addr"}, fail_addr_a, 0);
        chk({tag, "_err_count"}, err_count_a, 0);
    endtask

    initial begin
        int n;
        rst = 1'b0;
        start = 1'b0;
        start_b = 1'b0;
        clear_faults();
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        chk("reset_b", {busy_b, done_b, pass_b, fail_addr_b, err_count_b}, 0);
        rst = 1'b1;

        run_a(0);

        clear_faults();
        sa0_a[5][3] = 1'b1;
        run_a(0);

        clear_faults();
        sa1_a[10][0] = 1'b1;
        sa0_a[3][7] = 1'b1;
        run_a(0);

        clear_faults();
        run_a(100);

        for (int t = 0; t < 5; t++) begin
            int nf;
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                int a;
                int b;
                a = $urandom_range(0, 15);
                b = $urandom_range(0, 7);
                if ($urandom_range(0, 1) == 1) sa0_a[a][b] = 1'b1;
                else sa1_a[a][b] = 1'b1;
            end
            run_a(0);
        end

        clear_faults();
        @(negedge clk);
        n = cyc;
        build_expected(n);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (cyc < n + 50) @(negedge clk);
        #1 rst = 1'b0;
        #1 check_all_zero("abort");
        acc_q.delete();
        res_q.delete();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        run_a(0);

        @(negedge clk);
        n = cyc;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        while (!done_b && cyc < n + 300) @(negedge clk);
        chk("sat_done_cycle", cyc, n + 241);
        chk("sat_err_count", err_count_b, 3);
        chk("sat_fail_addr", fail_addr_b, 0);
        chk("sat_pass", pass_b, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
